// File: rtl/grasspopper_pkg.sv
// Shared Kuznyechik definitions: block geometry, FSM states, S-box tables,
// linear-transform coefficients and GF(2^8) arithmetic.
package grasspopper_pkg;

  localparam int BLK_W  = 128;
  localparam int ROUNDS = 10;

  // Low byte of the field modulus x^8 + x^7 + x^6 + x + 1 (0x1C3).
  localparam logic [7:0] GF_POLY = 8'hC3;

  typedef enum logic [2:0] {IDLE, XK, LINV, SINV, XR, DONE} fsm_state_e;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // L_COEF[j] multiplies byte a_j in l().
  localparam logic [7:0] L_COEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
    end
    return p;
  endfunction

  // The inverse S-box is derived from PI at elaboration so the two can never disagree.
  function automatic logic [255:0][7:0] invert_pi();
    logic [255:0][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[PI[i]] = 8'(i);
    return r;
  endfunction

  localparam logic [255:0][7:0] PI_INV = invert_pi();

endpackage

// File: rtl/grasspopper_decoder_if.sv
// Block/key handshake between the decryptor and its requester/key store.
interface grasspopper_decoder_if;
  import grasspopper_pkg::*;

  logic [BLK_W-1:0] data_i;
  logic             start;
  logic [BLK_W-1:0] rk_i;
  logic [3:0]       rk_idx_o;
  logic [BLK_W-1:0] data_o;
  logic             valid;
  logic             busy;

  modport master (output data_i, start, rk_i, input rk_idx_o, data_o, valid, busy);
  modport slave  (input data_i, start, rk_i, output rk_idx_o, data_o, valid, busy);

endinterface

// File: rtl/grasspopper_rinv.sv
// One inverse-R step: shift the block up a byte and rebuild a0 from l().
module grasspopper_rinv
  import grasspopper_pkg::*;
(
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  logic [7:0] acc;

  // NOTE: every variable written here is given a value on every path, so no latch is inferred.
  always_comb begin
    // The old top byte sits in the coefficient-1 slot of l().
    acc = din[127:120];
    for (int k = 1; k < 16; k++) acc = acc ^ gf_mul(din[8*(k-1) +: 8], L_COEF[k]);
    dout = {din[119:0], acc};
  end

endmodule

// File: rtl/grasspopper_decoder.sv
// Iterative Kuznyechik block decryptor: K10 whitening, then nine rounds of
// byte-serial L^-1, S^-1 and round-key XOR.
module grasspopper_decoder
  import grasspopper_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  grasspopper_decoder_if.slave bus
);

  fsm_state_e       state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [BLK_W-1:0] st, st_n;
  logic [BLK_W-1:0] out_q, out_n;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;
  logic [BLK_W-1:0] rinv_out;
  logic [BLK_W-1:0] sinv_out;

  grasspopper_rinv u_rinv (.din(st), .dout(rinv_out));

  always_comb begin
    sinv_out = '0;
    for (int b = 0; b < 16; b++) sinv_out[8*b +: 8] = PI_INV[st[8*b +: 8]];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    st_n    = st;
    out_n   = out_q;
    valid_n = 1'b0;
    busy_n  = busy_q;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          st_n    = bus.data_i;
          idx_n   = 4'(ROUNDS - 1);
          busy_n  = 1'b1;
          state_n = XK;
        end
      end
      XK: begin
        st_n    = st ^ bus.rk_i;
        idx_n   = idx - 4'd1;
        cnt_n   = '0;
        state_n = LINV;
      end
      LINV: begin
        st_n  = rinv_out;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd15) state_n = SINV;
      end
      SINV: begin
        st_n    = sinv_out;
        state_n = XR;
      end
      XR: begin
        st_n = st ^ bus.rk_i;
        if (idx == 4'd0) begin
          out_n   = st ^ bus.rk_i;
          valid_n = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end else begin
          idx_n   = idx - 4'd1;
          state_n = LINV;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 4'(ROUNDS - 1);
      st      <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      st      <= st_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.rk_idx_o = idx;
  assign bus.data_o   = out_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_grasspopper_decoder.sv
// Directed bench for grasspopper_decoder using the GOST R 34.12-2015 test key,
// plus round trips through an independent forward-cipher model.
module tb_grasspopper_decoder;
  import grasspopper_pkg::*;

  localparam logic [127:0] CT_STD = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] PT_STD = 128'h1122334455667700ffeeddccbbaa9988;
  localparam int           LAT    = 163;

  localparam logic [127:0] RK [10] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  localparam logic [7:0] COEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  grasspopper_decoder_if bus ();

  grasspopper_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Key-schedule store model: combinational lookup by the requested index.
  always_comb bus.rk_i = (bus.rk_idx_o < 4'd10) ? RK[bus.rk_idx_o] : '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

  // Forward cipher: LSX rounds with K1..K9, then K10.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] a;
    logic [7:0]   l;
    a = pt;
    for (int r = 0; r < 9; r++) begin
      a = a ^ RK[r];
      for (int j = 0; j < 16; j++) a[8*j +: 8] = PI[a[8*j +: 8]];
      for (int s = 0; s < 16; s++) begin
        l = 8'h00;
        for (int j = 0; j < 16; j++) l = l ^ gmul(a[8*j +: 8], COEF[j]);
        a = {l, a[127:8]};
      end
    end
    return a ^ RK[9];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] ct);
    bus.data_i = ct;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (bus.valid === 1'b1) begin
        edges = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.data_i = '0;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.valid !== 1'b0)     begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.data_o !== 128'h0)  begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    n_cmp++; if (bus.rk_idx_o !== 4'd9)  begin n_bad++; $display("FAIL reset_idx: got %0d want 9", bus.rk_idx_o); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_decrypt();
    logic [3:0] exp_idx;
    start_block(CT_STD);
    n_cmp++; if (bus.rk_idx_o !== 4'd9) begin n_bad++; $display("FAIL xk_idx: got %0d want 9", bus.rk_idx_o); end
    n_cmp++; if (bus.busy !== 1'b1)     begin n_bad++; $display("FAIL xk_busy: got %b want 1", bus.busy); end
    for (int e = 1; e <= LAT; e++) begin
      tick();
      if (e < LAT) begin
        exp_idx = 4'(8 - (e - 1) / 18);
        n_cmp++;
        if (bus.rk_idx_o !== exp_idx) begin
          n_bad++; $display("FAIL idx_trace edge %0d: got %0d want %0d", e, bus.rk_idx_o, exp_idx);
        end
        n_cmp++;
        if ({bus.busy, bus.valid} !== 2'b10) begin
          n_bad++; $display("FAIL busy_valid edge %0d: got %b want 10", e, {bus.busy, bus.valid});
        end
      end
    end
    n_cmp++; if (bus.valid !== 1'b1)   begin n_bad++; $display("FAIL done_valid: got %b want 1", bus.valid); end
    n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL done_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.data_o !== PT_STD) begin n_bad++; $display("FAIL std_plain: got %h want %h", bus.data_o, PT_STD); end
    tick();
    n_cmp++; if (bus.valid !== 1'b0)   begin n_bad++; $display("FAIL valid_pulse: got %b want 0", bus.valid); end
    n_cmp++; if (bus.data_o !== PT_STD) begin n_bad++; $display("FAIL data_hold: got %h want %h", bus.data_o, PT_STD); end
  endtask

  task automatic test_start_ignored();
    int edges;
    int extra;
    start_block(CT_STD);
    edges = -1;
    for (int n = 1; n <= 400; n++) begin
      bus.start  = n[0];
      bus.data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      if (bus.valid === 1'b1) begin
        edges = n;
        break;
      end
    end
    bus.start = 1'b0;
    n_cmp++; if (edges !== LAT)         begin n_bad++; $display("FAIL toggle_latency: got %0d want %0d", edges, LAT); end
    n_cmp++; if (bus.data_o !== PT_STD) begin n_bad++; $display("FAIL toggle_plain: got %h want %h", bus.data_o, PT_STD); end
    extra = 0;
    repeat (5) begin
      tick();
      if (bus.valid === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0)        begin n_bad++; $display("FAIL toggle_extra_valid: got %0d want 0", extra); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL toggle_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int edges;
    start_block(CT_STD);
    repeat (49) tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.valid !== 1'b0)    begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.data_o !== 128'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0", bus.data_o); end
    n_cmp++; if (bus.rk_idx_o !== 4'd9) begin n_bad++; $display("FAIL mid_reset_idx: got %0d want 9", bus.rk_idx_o); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    start_block(CT_STD);
    wait_valid(edges);
    n_cmp++; if (edges !== LAT)         begin n_bad++; $display("FAIL post_reset_latency: got %0d want %0d", edges, LAT); end
    n_cmp++; if (bus.data_o !== PT_STD) begin n_bad++; $display("FAIL post_reset_plain: got %h want %h", bus.data_o, PT_STD); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt2;
    logic [127:0] ct2;
    int e1;
    int e2;
    pt2 = 128'h0123456789abcdeffedcba9876543210;
    ct2 = encrypt(pt2);
    bus.data_i = CT_STD;
    bus.start  = 1'b1;
    tick();
    e1 = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (bus.valid === 1'b1) begin
        e1 = n;
        break;
      end
    end
    n_cmp++; if (e1 !== LAT)            begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", e1, LAT); end
    n_cmp++; if (bus.data_o !== PT_STD) begin n_bad++; $display("FAIL b2b_first_plain: got %h want %h", bus.data_o, PT_STD); end
    bus.data_i = ct2;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.valid} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_accept_in_done: got %b want 10", {bus.busy, bus.valid});
    end
    wait_valid(e2);
    n_cmp++; if (e2 + 1 !== 164)     begin n_bad++; $display("FAIL b2b_pulse_gap: got %0d want 164", e2 + 1); end
    n_cmp++; if (bus.data_o !== pt2) begin n_bad++; $display("FAIL b2b_second_plain: got %h want %h", bus.data_o, pt2); end
  endtask

  task automatic test_round_trip();
    logic [127:0] pt;
    int edges;
    for (int i = 0; i < 12; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_block(encrypt(pt));
      wait_valid(edges);
      n_cmp++;
      if (edges !== LAT || bus.data_o !== pt) begin
        n_bad++; $display("FAIL round_trip %0d: got %h after %0d edges want %h after %0d", i, bus.data_o, edges, pt, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decrypt();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
